// File: rtl/dag_circ.sv
// dag_circ: dual-channel data address generator.
// Channel 0 (DAG1) produces data-memory addresses and channel 1 (DAG2)
// produces program-memory addresses. Each channel has NREG I/M/B/L registers,
// pre-/post-modify addressing and circular-buffer wrap. Registers are loaded
// and read back over the bus-connect path, with same-cycle write forwarding.
module dag_circ #(
  parameter int AW   = 16,
  parameter int NREG = 8,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps_dg_dm_en,
  input  logic          ps_dg_dm_mdfy,
  input  logic [RW-1:0] ps_dg_dm_iadd,
  input  logic [RW-1:0] ps_dg_dm_madd,
  input  logic          ps_dg_pm_en,
  input  logic          ps_dg_pm_mdfy,
  input  logic [RW-1:0] ps_dg_pm_iadd,
  input  logic [RW-1:0] ps_dg_pm_madd,
  input  logic          ps_dg_wrt_en,
  input  logic [RW+2:0] ps_dg_wrt_add,
  input  logic [RW+2:0] ps_dg_rd_add,
  input  logic [AW-1:0] bc_dt_out,
  output logic [AW-1:0] dg_bc_dt,
  output logic [AW-1:0] dg_dm_add,
  output logic          dg_dm_vld,
  output logic [AW-1:0] dg_pm_add,
  output logic          dg_pm_vld
);

  localparam logic [1:0] TYPE_M = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_B = 2'b10;
  localparam logic [1:0] TYPE_L = 2'b11;

  // Register file: first index is the channel (0 = DAG1, 1 = DAG2).
  logic [AW-1:0] i_r [2][NREG];
  logic [AW-1:0] m_r [2][NREG];
  logic [AW-1:0] b_r [2][NREG];
  logic [AW-1:0] l_r [2][NREG];

  logic [AW-1:0] dm_add_r;
  logic          dm_vld_r;
  logic [AW-1:0] pm_add_r;
  logic          pm_vld_r;

  logic [1:0]    wrt_type_s;
  logic          wrt_chan_s;
  logic [RW-1:0] wrt_idx_s;
  logic [1:0]    rd_type_s;
  logic          rd_chan_s;
  logic [RW-1:0] rd_idx_s;

  logic [AW-1:0] dm_i_s;
  logic [AW-1:0] dm_mod_s;
  logic [AW-1:0] pm_i_s;
  logic [AW-1:0] pm_mod_s;
  logic [AW-1:0] rd_reg_s;

  // Circular modify: I+M with a single correction by L against the window
  // [B, B+L). L==0 means plain linear arithmetic modulo 2^AW. The sum is
  // kept in AW+1 bits so a negative result and an overflow past 2^AW are
  // both distinguishable from an in-range value.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] i_v,
                                             input logic [AW-1:0] m_v,
                                             input logic [AW-1:0] b_v,
                                             input logic [AW-1:0] l_v);
    logic signed [AW:0] sum_v;
    logic [AW:0]        lim_v;
    logic [AW-1:0]      res_v;
    sum_v = $signed({1'b0, i_v}) + $signed({m_v[AW-1], m_v});
    lim_v = {1'b0, b_v} + {1'b0, l_v};
    if (l_v == {AW{1'b0}}) begin
      res_v = sum_v[AW-1:0];
    end else if (m_v[AW-1] == 1'b0) begin
      // Non-negative step: sum is unsigned here, possibly above 2^AW-1.
      if ($unsigned(sum_v) >= lim_v) begin
        res_v = sum_v[AW-1:0] - l_v;
      end else begin
        res_v = sum_v[AW-1:0];
      end
    end else begin
      // Negative step: sum fits as a signed AW+1 value.
      if (sum_v < $signed({1'b0, b_v})) begin
        res_v = sum_v[AW-1:0] + l_v;
      end else begin
        res_v = sum_v[AW-1:0];
      end
    end
    return res_v;
  endfunction

  assign wrt_type_s = ps_dg_wrt_add[RW+2:RW+1];
  assign wrt_chan_s = ps_dg_wrt_add[RW];
  assign wrt_idx_s  = ps_dg_wrt_add[RW-1:0];
  assign rd_type_s  = ps_dg_rd_add[RW+2:RW+1];
  assign rd_chan_s  = ps_dg_rd_add[RW];
  assign rd_idx_s   = ps_dg_rd_add[RW-1:0];

  // Per-channel current index and modified address, from pre-edge state.
  always_comb begin
    dm_i_s   = i_r[0][ps_dg_dm_iadd];
    dm_mod_s = wrap_add(i_r[0][ps_dg_dm_iadd], m_r[0][ps_dg_dm_madd],
                        b_r[0][ps_dg_dm_iadd], l_r[0][ps_dg_dm_iadd]);
    pm_i_s   = i_r[1][ps_dg_pm_iadd];
    pm_mod_s = wrap_add(i_r[1][ps_dg_pm_iadd], m_r[1][ps_dg_pm_madd],
                        b_r[1][ps_dg_pm_iadd], l_r[1][ps_dg_pm_iadd]);
  end

  // Read-back mux with forwarding of a same-cycle write to the same register.
  always_comb begin
    rd_reg_s = {AW{1'b0}};
    case (rd_type_s)
      TYPE_M:  rd_reg_s = m_r[rd_chan_s][rd_idx_s];
      TYPE_I:  rd_reg_s = i_r[rd_chan_s][rd_idx_s];
      TYPE_B:  rd_reg_s = b_r[rd_chan_s][rd_idx_s];
      TYPE_L:  rd_reg_s = l_r[rd_chan_s][rd_idx_s];
      default: rd_reg_s = {AW{1'b0}};
    endcase
    if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add)) begin
      dg_bc_dt = bc_dt_out;
    end else begin
      dg_bc_dt = rd_reg_s;
    end
  end

  // Register file: post-modify updates first, explicit write last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < NREG; k++) begin
          i_r[c][k] <= {AW{1'b0}};
          m_r[c][k] <= {AW{1'b0}};
          b_r[c][k] <= {AW{1'b0}};
          l_r[c][k] <= {AW{1'b0}};
        end
      end
    end else begin
      if (ps_dg_dm_en && !ps_dg_dm_mdfy) begin
        i_r[0][ps_dg_dm_iadd] <= dm_mod_s;
      end
      if (ps_dg_pm_en && !ps_dg_pm_mdfy) begin
        i_r[1][ps_dg_pm_iadd] <= pm_mod_s;
      end
      if (ps_dg_wrt_en) begin
        case (wrt_type_s)
          TYPE_M:  m_r[wrt_chan_s][wrt_idx_s] <= bc_dt_out;
          TYPE_I:  i_r[wrt_chan_s][wrt_idx_s] <= bc_dt_out;
          TYPE_B:  b_r[wrt_chan_s][wrt_idx_s] <= bc_dt_out;
          TYPE_L:  l_r[wrt_chan_s][wrt_idx_s] <= bc_dt_out;
          default: m_r[wrt_chan_s][wrt_idx_s] <= m_r[wrt_chan_s][wrt_idx_s];
        endcase
      end
    end
  end

  // Registered address outputs; the address holds when no access is made.
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_add_r <= {AW{1'b0}};
      dm_vld_r <= 1'b0;
      pm_add_r <= {AW{1'b0}};
      pm_vld_r <= 1'b0;
    end else begin
      dm_vld_r <= ps_dg_dm_en;
      pm_vld_r <= ps_dg_pm_en;
      if (ps_dg_dm_en) begin
        dm_add_r <= ps_dg_dm_mdfy ? dm_mod_s : dm_i_s;
      end
      if (ps_dg_pm_en) begin
        pm_add_r <= ps_dg_pm_mdfy ? pm_mod_s : pm_i_s;
      end
    end
  end

  assign dg_dm_add = dm_add_r;
  assign dg_dm_vld = dm_vld_r;
  assign dg_pm_add = pm_add_r;
  assign dg_pm_vld = pm_vld_r;

endmodule

// File: tb/tb_dag_circ.sv
// Testbench for dag_circ: directed vector table, hand-written reset and
// collision sequences, then randomized traffic against a behavioural model.
module tb_dag_circ;

  localparam int AW   = 16;
  localparam int NREG = 8;
  localparam int RW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ps_dg_dm_en, ps_dg_dm_mdfy;
  logic [RW-1:0] ps_dg_dm_iadd, ps_dg_dm_madd;
  logic          ps_dg_pm_en, ps_dg_pm_mdfy;
  logic [RW-1:0] ps_dg_pm_iadd, ps_dg_pm_madd;
  logic          ps_dg_wrt_en;
  logic [RW+2:0] ps_dg_wrt_add, ps_dg_rd_add;
  logic [AW-1:0] bc_dt_out, dg_bc_dt, dg_dm_add, dg_pm_add;
  logic          dg_dm_vld, dg_pm_vld;

  always #5 clk = ~clk;

  dag_circ #(.AW(AW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .ps_dg_dm_en(ps_dg_dm_en), .ps_dg_dm_mdfy(ps_dg_dm_mdfy),
    .ps_dg_dm_iadd(ps_dg_dm_iadd), .ps_dg_dm_madd(ps_dg_dm_madd),
    .ps_dg_pm_en(ps_dg_pm_en), .ps_dg_pm_mdfy(ps_dg_pm_mdfy),
    .ps_dg_pm_iadd(ps_dg_pm_iadd), .ps_dg_pm_madd(ps_dg_pm_madd),
    .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
    .ps_dg_rd_add(ps_dg_rd_add), .bc_dt_out(bc_dt_out), .dg_bc_dt(dg_bc_dt),
    .dg_dm_add(dg_dm_add), .dg_dm_vld(dg_dm_vld),
    .dg_pm_add(dg_pm_add), .dg_pm_vld(dg_pm_vld)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [15:0] md_i [2][8];
  logic [15:0] md_m [2][8];
  logic [15:0] md_b [2][8];
  logic [15:0] md_l [2][8];
  logic [15:0] e_dm_add, e_pm_add;
  logic        e_dm_vld, e_pm_vld;
  logic [15:0] rd_seen;

  typedef struct {
    logic        wen;  logic [5:0] wadd; logic [15:0] wdat; logic [5:0] radd;
    logic        den;  logic dmd; logic [2:0] di; logic [2:0] dm;
    logic        pen;  logic pmd; logic [2:0] pi; logic [2:0] pm;
    logic [15:0] e_rd; logic [15:0] e_dm; logic e_dv; logic [15:0] e_pm; logic e_pv;
  } vec_t;

  vec_t tbl [25];

  function automatic logic [5:0] wa(input int t, input int c, input int k);
    logic [5:0] a;
    a = {2'(t), 1'(c), 3'(k)};
    return a;
  endfunction

  function automatic vec_t mk(input logic wen, input logic [5:0] wadd, input logic [15:0] wdat,
                              input logic [5:0] radd, input logic den, input logic dmd,
                              input logic [2:0] di, input logic [2:0] dm, input logic pen,
                              input logic pmd, input logic [2:0] pi, input logic [2:0] pm,
                              input logic [15:0] e_rd, input logic [15:0] e_dm, input logic e_dv,
                              input logic [15:0] e_pm, input logic e_pv);
    vec_t v;
    v.wen = wen; v.wadd = wadd; v.wdat = wdat; v.radd = radd;
    v.den = den; v.dmd = dmd; v.di = di; v.dm = dm;
    v.pen = pen; v.pmd = pmd; v.pi = pi; v.pm = pm;
    v.e_rd = e_rd; v.e_dm = e_dm; v.e_dv = e_dv; v.e_pm = e_pm; v.e_pv = e_pv;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_get(input logic [5:0] a);
    case (a[5:4])
      2'd0:    return md_m[a[3]][a[2:0]];
      2'd1:    return md_i[a[3]][a[2:0]];
      2'd2:    return md_b[a[3]][a[2:0]];
      default: return md_l[a[3]][a[2:0]];
    endcase
  endfunction

  // Modify rule in plain integer arithmetic: signed step, one correction by L.
  function automatic logic [15:0] model_wrap(input logic [15:0] i, input logic [15:0] m,
                                             input logic [15:0] b, input logic [15:0] l);
    longint sum;
    longint lo;
    longint hi;
    sum = longint'(i) + longint'($signed(m));
    lo  = longint'(b);
    hi  = longint'(b) + longint'(l);
    if (l != 16'd0) begin
      if ($signed(m) >= 0) begin
        if (sum >= hi) sum = sum - longint'(l);
      end else begin
        if (sum < lo) sum = sum + longint'(l);
      end
    end
    return sum[15:0];
  endfunction

  task automatic model_edge();
    logic [15:0] di, dn, pi, pn;
    if (rst) begin
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 8; k++) begin
          md_i[c][k] = 16'd0; md_m[c][k] = 16'd0; md_b[c][k] = 16'd0; md_l[c][k] = 16'd0;
        end
      e_dm_add = 16'd0; e_pm_add = 16'd0; e_dm_vld = 1'b0; e_pm_vld = 1'b0;
    end else begin
      di = md_i[0][ps_dg_dm_iadd];
      dn = model_wrap(di, md_m[0][ps_dg_dm_madd], md_b[0][ps_dg_dm_iadd], md_l[0][ps_dg_dm_iadd]);
      pi = md_i[1][ps_dg_pm_iadd];
      pn = model_wrap(pi, md_m[1][ps_dg_pm_madd], md_b[1][ps_dg_pm_iadd], md_l[1][ps_dg_pm_iadd]);
      e_dm_vld = ps_dg_dm_en;
      e_pm_vld = ps_dg_pm_en;
      if (ps_dg_dm_en) begin
        e_dm_add = ps_dg_dm_mdfy ? dn : di;
        if (!ps_dg_dm_mdfy) md_i[0][ps_dg_dm_iadd] = dn;
      end
      if (ps_dg_pm_en) begin
        e_pm_add = ps_dg_pm_mdfy ? pn : pi;
        if (!ps_dg_pm_mdfy) md_i[1][ps_dg_pm_iadd] = pn;
      end
      if (ps_dg_wrt_en) begin
        case (ps_dg_wrt_add[5:4])
          2'd0:    md_m[ps_dg_wrt_add[3]][ps_dg_wrt_add[2:0]] = bc_dt_out;
          2'd1:    md_i[ps_dg_wrt_add[3]][ps_dg_wrt_add[2:0]] = bc_dt_out;
          2'd2:    md_b[ps_dg_wrt_add[3]][ps_dg_wrt_add[2:0]] = bc_dt_out;
          default: md_l[ps_dg_wrt_add[3]][ps_dg_wrt_add[2:0]] = bc_dt_out;
        endcase
      end
    end
  endtask

  // One cycle: check read-back before the edge, then registered outputs after.
  task automatic step(input string tag);
    logic [15:0] exp_rd;
    exp_rd = (ps_dg_wrt_en && ps_dg_wrt_add == ps_dg_rd_add) ? bc_dt_out : model_get(ps_dg_rd_add);
    #1;
    rd_seen = dg_bc_dt;
    check({tag, " rd"}, dg_bc_dt, exp_rd);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, " dm_add"}, dg_dm_add, e_dm_add);
    check({tag, " dm_vld"}, 16'(dg_dm_vld), 16'(e_dm_vld));
    check({tag, " pm_add"}, dg_pm_add, e_pm_add);
    check({tag, " pm_vld"}, 16'(dg_pm_vld), 16'(e_pm_vld));
  endtask

  task automatic idle();
    ps_dg_dm_en = 1'b0; ps_dg_dm_mdfy = 1'b0; ps_dg_dm_iadd = 3'd0; ps_dg_dm_madd = 3'd0;
    ps_dg_pm_en = 1'b0; ps_dg_pm_mdfy = 1'b0; ps_dg_pm_iadd = 3'd0; ps_dg_pm_madd = 3'd0;
    ps_dg_wrt_en = 1'b0; ps_dg_wrt_add = 6'd0; bc_dt_out = 16'd0;
  endtask

  initial begin
    rst = 1'b1;
    ps_dg_rd_add = 6'd0;
    idle();
    repeat (2) @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;

    // Reset sequence: load I0, use it, then reset with traffic present.
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = wa(1, 0, 0); bc_dt_out = 16'h0100;
    ps_dg_rd_add = wa(1, 0, 0);
    step("rst_load");
    idle();
    ps_dg_dm_en = 1'b1;
    step("rst_use");
    check("pre_rst dm_add", dg_dm_add, 16'h0100);
    rst = 1'b1;
    ps_dg_pm_en = 1'b1;
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = wa(2, 0, 0); bc_dt_out = 16'h0055;
    step("rst_hold");
    check("rst stored rd", rd_seen, 16'h0100);
    check("rst dm_add", dg_dm_add, 16'h0000);
    check("rst dm_vld", 16'(dg_dm_vld), 16'h0000);
    check("rst pm_add", dg_pm_add, 16'h0000);
    check("rst pm_vld", 16'(dg_pm_vld), 16'h0000);
    rst = 1'b0;
    idle();
    step("rst_after");
    check("rst I0 cleared", rd_seen, 16'h0000);

    // Directed vectors: linear, circular, negative, pre-modify, collision.
    tbl[0]  = mk(1'b1, wa(1,0,0), 16'h0010, wa(1,0,0), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0010, 16'h0000,1'b0, 16'h0000,1'b0);
    tbl[1]  = mk(1'b1, wa(0,0,1), 16'h0004, wa(1,0,0), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0010, 16'h0000,1'b0, 16'h0000,1'b0);
    tbl[2]  = mk(1'b0, 6'd0, 16'h0000, wa(1,0,0), 1'b1,1'b0,3'd0,3'd1, 1'b0,1'b0,3'd0,3'd0, 16'h0010, 16'h0010,1'b1, 16'h0000,1'b0);
    tbl[3]  = mk(1'b0, 6'd0, 16'h0000, wa(1,0,0), 1'b1,1'b0,3'd0,3'd1, 1'b0,1'b0,3'd0,3'd0, 16'h0014, 16'h0014,1'b1, 16'h0000,1'b0);
    tbl[4]  = mk(1'b0, 6'd0, 16'h0000, wa(1,0,0), 1'b1,1'b0,3'd0,3'd1, 1'b0,1'b0,3'd0,3'd0, 16'h0018, 16'h0018,1'b1, 16'h0000,1'b0);
    tbl[5]  = mk(1'b0, 6'd0, 16'h0000, wa(1,0,0), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h001C, 16'h0018,1'b0, 16'h0000,1'b0);
    tbl[6]  = mk(1'b1, wa(2,1,2), 16'h0200, wa(2,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0200, 16'h0018,1'b0, 16'h0000,1'b0);
    tbl[7]  = mk(1'b1, wa(3,1,2), 16'h0005, wa(3,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0005, 16'h0018,1'b0, 16'h0000,1'b0);
    tbl[8]  = mk(1'b1, wa(1,1,2), 16'h0203, wa(1,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0203, 16'h0018,1'b0, 16'h0000,1'b0);
    tbl[9]  = mk(1'b1, wa(0,1,0), 16'h0002, wa(0,1,0), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0002, 16'h0018,1'b0, 16'h0000,1'b0);
    tbl[10] = mk(1'b0, 6'd0, 16'h0000, wa(1,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b1,1'b0,3'd2,3'd0, 16'h0203, 16'h0018,1'b0, 16'h0203,1'b1);
    tbl[11] = mk(1'b0, 6'd0, 16'h0000, wa(1,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b1,1'b0,3'd2,3'd0, 16'h0200, 16'h0018,1'b0, 16'h0200,1'b1);
    tbl[12] = mk(1'b0, 6'd0, 16'h0000, wa(1,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b1,1'b0,3'd2,3'd0, 16'h0202, 16'h0018,1'b0, 16'h0202,1'b1);
    tbl[13] = mk(1'b0, 6'd0, 16'h0000, wa(1,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b1,1'b0,3'd2,3'd0, 16'h0204, 16'h0018,1'b0, 16'h0204,1'b1);
    tbl[14] = mk(1'b1, wa(1,1,2), 16'h0200, wa(1,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0200, 16'h0018,1'b0, 16'h0204,1'b0);
    tbl[15] = mk(1'b1, wa(0,1,0), 16'hFFFE, wa(0,1,0), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'hFFFE, 16'h0018,1'b0, 16'h0204,1'b0);
    tbl[16] = mk(1'b0, 6'd0, 16'h0000, wa(1,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b1,1'b0,3'd2,3'd0, 16'h0200, 16'h0018,1'b0, 16'h0200,1'b1);
    tbl[17] = mk(1'b0, 6'd0, 16'h0000, wa(1,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0203, 16'h0018,1'b0, 16'h0200,1'b0);
    tbl[18] = mk(1'b1, wa(1,0,3), 16'h0040, wa(1,0,3), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0040, 16'h0018,1'b0, 16'h0200,1'b0);
    tbl[19] = mk(1'b1, wa(0,0,3), 16'h0008, wa(0,0,3), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0008, 16'h0018,1'b0, 16'h0200,1'b0);
    tbl[20] = mk(1'b0, 6'd0, 16'h0000, wa(1,0,3), 1'b1,1'b1,3'd3,3'd3, 1'b1,1'b0,3'd2,3'd0, 16'h0040, 16'h0048,1'b1, 16'h0203,1'b1);
    tbl[21] = mk(1'b0, 6'd0, 16'h0000, wa(1,0,3), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0040, 16'h0048,1'b0, 16'h0203,1'b0);
    tbl[22] = mk(1'b0, 6'd0, 16'h0000, wa(1,1,2), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h0201, 16'h0048,1'b0, 16'h0203,1'b0);
    tbl[23] = mk(1'b1, wa(1,0,0), 16'h1234, wa(1,0,0), 1'b1,1'b0,3'd0,3'd1, 1'b0,1'b0,3'd0,3'd0, 16'h1234, 16'h001C,1'b1, 16'h0203,1'b0);
    tbl[24] = mk(1'b0, 6'd0, 16'h0000, wa(1,0,0), 1'b0,1'b0,3'd0,3'd0, 1'b0,1'b0,3'd0,3'd0, 16'h1234, 16'h001C,1'b0, 16'h0203,1'b0);

    for (int r = 0; r < 25; r++) begin
      ps_dg_wrt_en = tbl[r].wen; ps_dg_wrt_add = tbl[r].wadd; bc_dt_out = tbl[r].wdat;
      ps_dg_rd_add = tbl[r].radd;
      ps_dg_dm_en = tbl[r].den; ps_dg_dm_mdfy = tbl[r].dmd;
      ps_dg_dm_iadd = tbl[r].di; ps_dg_dm_madd = tbl[r].dm;
      ps_dg_pm_en = tbl[r].pen; ps_dg_pm_mdfy = tbl[r].pmd;
      ps_dg_pm_iadd = tbl[r].pi; ps_dg_pm_madd = tbl[r].pm;
      step($sformatf("vec%0d", r));
      check($sformatf("vec%0d tbl_rd", r), rd_seen, tbl[r].e_rd);
      check($sformatf("vec%0d tbl_dm", r), dg_dm_add, tbl[r].e_dm);
      check($sformatf("vec%0d tbl_dv", r), 16'(dg_dm_vld), 16'(tbl[r].e_dv));
      check($sformatf("vec%0d tbl_pm", r), dg_pm_add, tbl[r].e_pm);
      check($sformatf("vec%0d tbl_pv", r), 16'(dg_pm_vld), 16'(tbl[r].e_pv));
    end

    // Randomized traffic: small values dominate so wraps happen often.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      ps_dg_wrt_en = ($urandom_range(0, 2) == 0);
      ps_dg_wrt_add = 6'($urandom);
      case ($urandom_range(0, 3))
        0:       bc_dt_out = 16'($urandom);
        1:       bc_dt_out = 16'd0 - 16'($urandom_range(1, 8));
        default: bc_dt_out = 16'($urandom_range(0, 24));
      endcase
      ps_dg_rd_add = ($urandom_range(0, 2) == 0) ? ps_dg_wrt_add : 6'($urandom);
      ps_dg_dm_en = 1'($urandom); ps_dg_dm_mdfy = 1'($urandom);
      ps_dg_dm_iadd = 3'($urandom); ps_dg_dm_madd = 3'($urandom);
      ps_dg_pm_en = 1'($urandom); ps_dg_pm_mdfy = 1'($urandom);
      ps_dg_pm_iadd = 3'($urandom); ps_dg_pm_madd = 3'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dag_circ.md
Name: dag_circ

Overview:
- Parametrised dual-channel data address generator.
- Channel 0 (DAG1) drives data-memory addresses; channel 1 (DAG2) drives program-memory addresses.
- Each channel owns NREG index (I), modify (M), base (B) and length (L) registers, supports pre-/post-modify addressing with circular-buffer wrap, and both channels can operate in the same cycle.
- Registers are loaded and read back over the bus-connect data path, with same-cycle write-to-read forwarding.

Parameters:
AW, 16, address/data width of I, M, B, L and all address outputs
NREG, 8, registers of each type per channel (power of 2, >=2)
RW, $clog2(NREG), register index width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ps_dg_dm_en  in  1  DAG1 access request this cycle
ps_dg_dm_mdfy  in  1  DAG1 mode: 1=pre-modify (I+M, no update), 0=post-modify (I, then update I)
ps_dg_dm_iadd  in  RW  DAG1 I/B/L select
ps_dg_dm_madd  in  RW  DAG1 M select
ps_dg_pm_en, ps_dg_pm_mdfy, ps_dg_pm_iadd, ps_dg_pm_madd  in  1/1/RW/RW  DAG2 equivalents
ps_dg_wrt_en  in  1  register write strobe
ps_dg_wrt_add  in  RW+3  {type[1:0] (00=M,01=I,10=B,11=L), chan, idx[RW-1:0]}
ps_dg_rd_add  in  RW+3  read-back select, same encoding
bc_dt_out  in  AW  write data from bus connect
dg_bc_dt  out  AW  read-back data to bus connect (combinational)
dg_dm_add  out  AW  DAG1 address (registered)
dg_dm_vld  out  1  dg_dm_add valid
dg_pm_add  out  AW  DAG2 address (registered)
dg_pm_vld  out  1  dg_pm_add valid

Behaviour:
- Reset (rst=1 at posedge clk):
  - All I/M/B/L cleared to 0.
  - dg_dm_add, dg_pm_add = 0; dg_dm_vld, dg_pm_vld = 0.
  - Reset overrides any access or write in that cycle.
- Address latency: 1 cycle.
  - Request sampled at edge N; address and vld=1 are presented after edge N.
  - vld=0 when en=0 at the previous edge; the address output holds its last value.
- Post-modify (mdfy=0):
  - Output address = I[iadd].
  - I[iadd] <= wrap(I[iadd]+M[madd]) at the same edge.
- Pre-modify (mdfy=1):
  - Output address = wrap(I[iadd]+M[madd]).
  - I is unchanged.
- Modify arithmetic:
  - M is two's-complement signed AW bits.
  - Intermediate sums are computed in AW+1 bits.
- wrap(), using the selected channel's B[iadd] and L[iadd]:
  - L==0: linear; result = (I+M) mod 2^AW.
  - L!=0, M>=0: if sum >= B+L then sum-L, else sum.
  - L!=0, M<0: if sum < B then sum+L, else sum.
  - Required precondition: |M| <= L and B <= I < B+L. Behaviour outside this is a plain single-correction result, with no error flag.
- Channels are independent; both may access in the same cycle with no stall.
- Register write takes effect at the edge where ps_dg_wrt_en=1.
- Write vs post-modify update to the same I register in the same cycle: the explicit write wins.
- Same-cycle post-modify access reads the pre-write I value for its output address.
- Read-back: dg_bc_dt = register selected by ps_dg_rd_add, combinational.
  - If ps_dg_wrt_en=1 and ps_dg_wrt_add==ps_dg_rd_add, dg_bc_dt = bc_dt_out (forward).
- Read-back during rst returns the stored value; registers clear at the edge.

Test Plan:
- Reset: load DAG1 I0=0x0100, assert rst for one edge -> I0 read-back 0x0000, both vld=0, both addresses 0x0000.
- Linear post-modify: DAG1 I0=0x0010, M1=0x0004, L0=0, three back-to-back accesses -> dg_dm_add 0x0010, 0x0014, 0x0018 with vld=1 each cycle; I0 ends at 0x001C.
- Circular wrap: DAG2 B2=0x0200, L2=5, I2=0x0203, M0=2, four post-modify accesses -> dg_pm_add 0x0203, 0x0200, 0x0202, 0x0204.
- Negative modify: DAG2 I2=0x0200 with M0=0xFFFE (-2), same B2/L2 -> next I2 = 0x0203.
- Pre-modify plus simultaneous channels: DAG1 pre-modify with I3=0x0040, M3=0x0008 and DAG2 post-modify in the same cycle -> dg_dm_add=0x0048 with I3 unchanged; DAG2 output and update both correct.
- Write/update collision and forwarding:
  - Post-modify DAG1 I0 while writing 0x1234 to I0 -> I0=0x1234 afterwards.
  - With wrt_add==rd_add, dg_bc_dt=0x1234 in the same cycle.
